// File: rtl/uart_sram_bridge.sv
// CPU data-SRAM port bridge: local word RAM plus an 8N1 UART transmitter page at UART_BASE.
// Optional macro UART_TX_FIFO_EN adds a 4-entry TX FIFO in front of the shifter.
module uart_sram_bridge #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          RAM_AW       = 10,
    parameter logic [31:0] UART_BASE    = 32'h1FAF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        uart_tx_pin
);
    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    logic              w_uart_sel;
    logic [15:0]       w_off;
    logic              w_rd;
    logic              w_data_wr;
    logic              w_ram_wr;
    logic [RAM_AW-1:0] w_idx;
    logic [31:0]       w_status;
    logic [31:0]       w_uart_rdata;

    tx_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [2:0]        r_bit, w_bit_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              r_pin, w_pin;
    logic              w_last;
    logic              w_take;
    logic              w_busy;
    logic              w_ready;
    logic [7:0]        w_byte;

    logic [31:0]       r_mem [0:(1<<RAM_AW)-1];
    logic [31:0]       r_rdata;

    // Upper address bits beyond the RAM index are ignored, so RAM aliases across the map.
    assign w_uart_sel = (data_sram_addr[31:16] == UART_BASE[31:16]);
    assign w_off      = data_sram_addr[15:0];
    assign w_idx      = data_sram_addr[RAM_AW+1:2];
    assign w_rd       = data_sram_en && (data_sram_wen == 4'b0000);
    assign w_data_wr  = data_sram_en && w_uart_sel && (w_off == 16'h0000) && data_sram_wen[0];
    assign w_ram_wr   = data_sram_en && !w_uart_sel && (data_sram_wen != 4'b0000);

    assign w_busy       = (r_state != S_IDLE);
    assign w_last       = (r_cnt == CNT_LAST);
    assign w_status     = {30'b0, w_busy, w_ready};
    assign w_uart_rdata = (w_off == 16'h0004) ? w_status : 32'h0;

`ifdef UART_TX_FIFO_EN
    logic [7:0] r_fifo [0:3];
    logic [1:0] r_wptr, r_rptr;
    logic [2:0] r_count;
    logic       w_start_req;
    logic       w_fifo_wr;
    logic       w_fifo_rd;

    // An empty FIFO is bypassed so an idle transmitter starts on the accepting edge.
    assign w_start_req = (r_state == S_IDLE) || ((r_state == S_STOP) && w_last);
    assign w_ready     = (r_count != 3'd4);
    assign w_take      = w_start_req && ((r_count != 3'd0) || w_data_wr);
    assign w_byte      = (r_count != 3'd0) ? r_fifo[r_rptr] : data_sram_wdata[7:0];
    assign w_fifo_rd   = w_take && (r_count != 3'd0);
    assign w_fifo_wr   = w_data_wr && w_ready && !(w_take && (r_count == 3'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_fifo_wr) r_wptr <= r_wptr + 2'd1;
            if (w_fifo_rd) r_rptr <= r_rptr + 2'd1;
            r_count <= r_count + {2'b0, w_fifo_wr} - {2'b0, w_fifo_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_wr) r_fifo[r_wptr] <= data_sram_wdata[7:0];
    end
`else
    assign w_ready = !w_busy;
    assign w_take  = (r_state == S_IDLE) && w_data_wr;
    assign w_byte  = data_sram_wdata[7:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pin       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_take) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = w_byte;
                end
            end
            S_START: begin
                w_pin = 1'b0;
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_pin = r_shift[0];
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                w_pin = 1'b1;
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (w_take) begin
                        w_state_nxt = S_START;
                        w_shift_nxt = w_byte;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The pin is registered from the state, so it trails the state by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_pin   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_pin   <= w_pin;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (w_rd) begin
            r_rdata <= w_uart_sel ? w_uart_rdata : r_mem[w_idx];
        end
    end

    assign data_sram_rdata = r_rdata;
    assign uart_tx_pin     = r_pin;
endmodule

// File: tb/tb_uart_sram_bridge.sv
// Randomized bench for uart_sram_bridge against a frame-list / word-array reference model.
module tb_uart_sram_bridge;
    localparam int CPB   = 20;
    localparam int AW    = 6;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'h0;
    logic [31:0] data_sram_addr = 32'h0;
    logic [31:0] data_sram_wdata = 32'h0;
    logic [31:0] data_sram_rdata;
    logic        uart_tx_pin;

    uart_sram_bridge #(.CLKS_PER_BIT(CPB), .RAM_AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_sram_en   (data_sram_en),
        .data_sram_wen  (data_sram_wen),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .uart_tx_pin    (uart_tx_pin)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit model_on = 1'b0;

    // Reference model: each accepted byte becomes a frame starting at an edge index.
    int          fr_acc[$];
    int          fr_start[$];
    logic [7:0]  fr_byte[$];
    logic [31:0] mem_m [0:(1<<AW)-1];
    logic [31:0] exp_rdata = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_busy(int m);
        foreach (fr_start[i]) if (fr_start[i] < m && m <= fr_start[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready(int m);
`ifdef UART_TX_FIFO_EN
        int p = 0;
        foreach (fr_start[i]) if (fr_acc[i] < m && fr_start[i] >= m) p++;
        return (p < 4);
`else
        return !m_busy(m);
`endif
    endfunction

    function automatic int last_end();
        if (fr_start.size() == 0) return 0;
        return fr_start[fr_start.size()-1] + FRAME;
    endfunction

    function automatic logic exp_pin(int e);
        int idx;
        foreach (fr_start[i]) begin
            if (e >= fr_start[i] + 1 && e < fr_start[i] + 1 + FRAME) begin
                idx = (e - fr_start[i] - 1) / CPB;
                if (idx == 0) return 1'b0;
                if (idx == 9) return 1'b1;
                return fr_byte[i][idx-1];
            end
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        logic uart;
        int   s;
        cyc = cyc + 1;
        if (rst) begin
            fr_acc.delete();
            fr_start.delete();
            fr_byte.delete();
            exp_rdata = 32'h0;
            model_on  = 1'b1;
        end else if (data_sram_en) begin
            uart = (data_sram_addr[31:16] == 16'h1FAF);
            if (data_sram_wen == 4'h0) begin
                if (uart)
                    exp_rdata = (data_sram_addr[15:0] == 16'h0004) ?
                                {30'b0, m_busy(cyc), m_ready(cyc)} : 32'h0;
                else
                    exp_rdata = mem_m[data_sram_addr[AW+1:2]];
            end else if (uart) begin
                if (data_sram_addr[15:0] == 16'h0000 && data_sram_wen[0] && m_ready(cyc)) begin
                    s = (last_end() > cyc) ? last_end() : cyc;
                    fr_acc.push_back(cyc);
                    fr_start.push_back(s);
                    fr_byte.push_back(data_sram_wdata[7:0]);
                end
            end else begin
                for (int i = 0; i < 4; i++)
                    if (data_sram_wen[i]) mem_m[data_sram_addr[AW+1:2]][8*i +: 8] = data_sram_wdata[8*i +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check_eq("rdata", data_sram_rdata, exp_rdata);
            check_eq("pin", {31'b0, uart_tx_pin}, {31'b0, exp_pin(cyc)});
        end
    end

    task automatic acc(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = a;
        data_sram_wdata = d;
        @(posedge clk); #1;
        data_sram_en  = 1'b0;
        data_sram_wen = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] ram_addr();
        logic [31:0] a;
        a = $urandom;
        if (a[31:16] == 16'h1FAF) a[31] = ~a[31];
        return a;
    endfunction

    initial begin
        logic [31:0] a, d;
        logic [15:0] off;
        int r, guard;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        acc(4'h0, 32'h1FAF_0004, 32'h0);
        check_eq("rst_status", data_sram_rdata, 32'h0000_0001);
        idle(3);
        check_eq("status_hold", data_sram_rdata, 32'h0000_0001);

        for (int i = 0; i < (1 << AW); i++) acc(4'hF, i << 2, $urandom);

        acc(4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        acc(4'b0100, 32'h0000_0010, 32'h0055_0000);
        acc(4'h0, 32'h0000_0010, 32'h0);
        check_eq("ram_byte", data_sram_rdata, 32'hDE55_BEEF);
        acc(4'h0, 32'h8000_0010 + (32'h1 << (AW + 2)), 32'h0);
        check_eq("ram_alias", data_sram_rdata, 32'hDE55_BEEF);

        acc(4'b0001, 32'h1FAF_0000, 32'h0000_0041);
        check_eq("pin_at_accept", {31'b0, uart_tx_pin}, 32'h1);
        idle(1);
        check_eq("pin_start", {31'b0, uart_tx_pin}, 32'h0);
        idle(3 * CPB);
        acc(4'h0, 32'h1FAF_0004, 32'h0);
`ifdef UART_TX_FIFO_EN
        check_eq("status_busy", data_sram_rdata, 32'h0000_0003);
`else
        check_eq("status_busy", data_sram_rdata, 32'h0000_0002);
`endif
        acc(4'b0001, 32'h1FAF_0000, 32'h0000_0042);
        idle(2 * FRAME);
        acc(4'h0, 32'h1FAF_0004, 32'h0);
        check_eq("status_after", data_sram_rdata, 32'h0000_0001);

        acc(4'b0001, 32'h1FAF_0000, 32'h41);
        acc(4'b0001, 32'h1FAF_0000, 32'h42);
        acc(4'b0001, 32'h1FAF_0000, 32'h43);
        idle(3 * FRAME + 10);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: acc(4'h0, ram_addr(), 32'h0);
                3, 4:    acc(4'($urandom_range(1, 15)), ram_addr(), $urandom);
                5:       acc(4'($urandom_range(0, 15)), 32'h1FAF_0000, $urandom);
                6, 7:    acc(4'h0, 32'h1FAF_0004, $urandom);
                8: begin
                    off = 16'($urandom);
                    if ($urandom_range(0, 1) == 1) off = 16'h0000;
                    acc(4'($urandom_range(0, 15)), {16'h1FAF, off}, $urandom);
                end
                default: idle($urandom_range(0, 2 * CPB));
            endcase
        end

        a = ram_addr();
        d = $urandom;
        acc(4'hF, a, d);
        acc(4'h0, a, 32'h0);
        check_eq("raw_fwd", data_sram_rdata, d);

        guard = 0;
        while (last_end() >= cyc && guard < 8 * FRAME) begin
            idle(1);
            guard++;
        end
        check_eq("drain_timeout", guard < 8 * FRAME, 32'h1);
        acc(4'b0001, 32'h1FAF_0000, 32'h0000_005A);
        idle(4 * CPB + CPB / 2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_eq("rst_pin", {31'b0, uart_tx_pin}, 32'h1);
        acc(4'h0, 32'h1FAF_0004, 32'h0);
        check_eq("rst_mid_status", data_sram_rdata, 32'h0000_0001);
        idle(FRAME + 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/uart_sram_bridge.md
# uart_sram_bridge

Memory-mapped bridge on the CPU data-SRAM port: decodes each access to either a small local word RAM or a UART transmitter mapped at 0x1FAF_0000. It sits between the CPU core's data-SRAM interface and the board's UART TX pin. Software reads a status register to poll for transmit readiness, then writes a byte to the data register to send it as an 8N1 serial frame.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200 baud).
- RAM_AW, default 10: local RAM word-address width (2^RAM_AW 32-bit words).
- UART_BASE, default 32'h1FAF_0000: UART register page base.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_sram_en  in  1  access strobe, one access per cycle.
- data_sram_wen  in  4  byte write enables; 0 means read.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  registered read data.
- uart_tx_pin  out  1  serial output, idle high.

## Operation
- Decode: addr[31:16] == UART_BASE[31:16] selects the UART page; every other address selects local RAM at word index addr[RAM_AW+1:2]. Upper address bits are ignored (aliasing).
- UART page, offset 0x0 (DATA):
  - A write with wen[0]=1 sends wdata[7:0].
  - A write with wen[0]=0 is ignored.
  - A read returns 0.
- UART page, offset 0x4 (STATUS), read-only:
  - bit0 = tx_ready (a write to DATA would be accepted).
  - bit1 = tx_busy (a frame is in progress).
  - bits 31:2 = 0.
- Other UART-page offsets read 0; writes to them are ignored.
- Local RAM: byte lane i is written when wen[i]=1. Contents are not reset.
- Reads (en=1, wen=0) update data_sram_rdata. Writes and idle cycles leave data_sram_rdata unchanged.
- Transmitter states:
  - IDLE: pin=1.
  - START: pin=0.
  - DATA: 8 bits, LSB first.
  - STOP: pin=1.
  - Each state or bit lasts exactly CLKS_PER_BIT cycles. STOP returns to IDLE, or goes directly to START if a byte is pending (FIFO build).
- A DATA write while tx_ready=0 is silently dropped.

## Timing
- Reset values: data_sram_rdata=0, uart_tx_pin=1, transmitter in IDLE, tx_busy=0, tx_ready=1, FIFO empty.
- Read latency is one cycle. An access sampled at edge N places its data on data_sram_rdata after edge N. The value is held until the next read.
- A DATA write is accepted at edge N. tx_busy=1 from edge N, so a STATUS read issued in the very next cycle already reports busy. uart_tx_pin goes low at edge N+1.
- Frame length is 10*CLKS_PER_BIT cycles. tx_busy clears at the end of STOP when nothing is pending.
- Reset asserted mid-frame aborts the frame immediately: pin=1 on the next edge and all pending bytes are discarded.
- A write to the local RAM followed by a read of the same address in the next cycle returns the new data (no hazard).

## Configuration
- UART_TX_FIFO_EN:
  - Defined: a 4-entry TX FIFO sits in front of the shifter. tx_ready = FIFO not full. Back-to-back frames are sent with no idle gap.
  - Undefined: single-byte transmitter. tx_ready = !tx_busy, and a write during a frame is dropped.

## Test plan
- Reset, then read 0x1FAF_0004 -> data_sram_rdata = 0x0000_0001 on the cycle after the access, and stays held after en drops.
- Write wen=4'b0001, wdata=0x41 to 0x1FAF_0000 -> pin low at N+1. Then, every 868 cycles, the pin shows 1,0,0,0,0,0,1,0 (LSB first), followed by a stop bit of 1 for 868 cycles, then idle high.
- Read STATUS during that frame -> 0x0000_0002 without FIFO, 0x0000_0003 with FIFO. Read STATUS after the frame -> 0x0000_0001.
- Without FIFO, write 0x42 mid-frame -> ignored; only the 0x41 frame appears. With FIFO, writes of 0x41,0x42,0x43 -> three contiguous frames.
- RAM: write 0xDEADBEEF to 0x0000_0010, then byte-write wen=4'b0100 with 0x00550000 -> reading 0x10 returns 0xDE55BEEF.
- Assert rst for one cycle at bit 3 of a frame -> pin=1 on the next edge, STATUS reads 0x0000_0001, no further bits are emitted.
